// File: rtl/fc_pkg.sv
// Shared types and default widths for the fully-connected layer sequencer and the CNN top.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fc_state_t;

  localparam int FC_FLATTENED_LENGTH  = 50;
  localparam int FC_CONV_DATA_WIDTH   = 8;
  localparam int FC_WEIGHT_DATA_WIDTH = 8;
  localparam int FC_OUTPUT_DATA_WIDTH = 32;

  // A single-entry buffer still needs a one-bit index.
  function automatic int fc_addr_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Registered unsigned multiply-accumulate; clear wins over enable, the sum wraps at OUT_W bits.
module fc_mac_unit #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [OUT_W-1:0] acc,
  output logic [OUT_W-1:0] acc_nxt
);

  localparam int PW = A_W + B_W;
  localparam int EW = (OUT_W > PW) ? OUT_W : PW;

  logic [EW-1:0]    prod_wide_s;
  logic [OUT_W-1:0] acc_d;
  logic [OUT_W-1:0] acc_q;

  // Next accumulator value: product is computed wide enough to be exact, then reduced modulo 2^OUT_W.
  always_comb begin
    prod_wide_s = EW'(a) * EW'(b);
    acc_d       = acc_q;
    if (clr) begin
      acc_d = {OUT_W{1'b0}};
    end else if (en) begin
      acc_d = acc_q + prod_wide_s[OUT_W-1:0];
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {OUT_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc     = acc_q;
  assign acc_nxt = acc_d;

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequential FC-layer controller: streams feature/weight pairs from synchronous buffers,
// accumulates one product per clock and hands the sum downstream over valid/ready.
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int FLATTENED_LENGTH          = FC_FLATTENED_LENGTH,
  parameter int CONVOLUTION_DATA_WIDTH    = FC_CONV_DATA_WIDTH,
  parameter int FULLYCONNECTED_DATA_WIDTH = FC_WEIGHT_DATA_WIDTH,
  parameter int OUTPUT_DATA_WIDTH         = FC_OUTPUT_DATA_WIDTH,
  parameter int ADDR_WIDTH                = fc_addr_width(FLATTENED_LENGTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 fc_start,
  input  logic                                 fc_abort,
  output logic                                 fc_busy,
  output logic                                 rd_en,
  output logic [ADDR_WIDTH-1:0]                rd_addr,
  input  logic [CONVOLUTION_DATA_WIDTH-1:0]    feature_rdata,
  input  logic [FULLYCONNECTED_DATA_WIDTH-1:0] weight_rdata,
  output logic [OUTPUT_DATA_WIDTH-1:0]         result,
  output logic                                 result_valid,
  input  logic                                 result_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FLATTENED_LENGTH - 1);

  fc_state_t                    state_d, state_q;
  logic [ADDR_WIDTH-1:0]        index_d, index_q;
  logic                         rd_en_d, rd_en_q;
  logic                         rd_en_dly_d, rd_en_dly_q;
  logic                         busy_d, busy_q;
  logic                         result_valid_d, result_valid_q;
  logic [OUTPUT_DATA_WIDTH-1:0] result_d, result_q;
  logic                         mac_clr_s;
  logic [OUTPUT_DATA_WIDTH-1:0] mac_acc_s;
  logic [OUTPUT_DATA_WIDTH-1:0] mac_acc_nxt_s;

  // Next-state, index, read pipeline and handshake logic; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    rd_en_dly_d = rd_en_q;
    result_d    = result_q;
    mac_clr_s   = 1'b0;
    if (fc_abort) begin
      state_d     = IDLE;
      rd_en_dly_d = 1'b0;
      mac_clr_s   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (fc_start) begin
            state_d   = RUN;
            index_d   = {ADDR_WIDTH{1'b0}};
            mac_clr_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          // index doubles as rd_addr, so it stops at the last entry and holds there.
          if (index_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            index_d = index_q + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          state_d  = DONE;
          result_d = mac_acc_nxt_s;
        end
        DONE: begin
          if (result_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    rd_en_d        = (state_d == RUN);
    busy_d         = (state_d != IDLE);
    result_valid_d = (state_d == DONE);
  end

  // State, index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      index_q        <= {ADDR_WIDTH{1'b0}};
      rd_en_q        <= 1'b0;
      rd_en_dly_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= {OUTPUT_DATA_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      rd_en_q        <= rd_en_d;
      rd_en_dly_q    <= rd_en_dly_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
    end
  end

  fc_mac_unit #(
    .A_W   (CONVOLUTION_DATA_WIDTH),
    .B_W   (FULLYCONNECTED_DATA_WIDTH),
    .OUT_W (OUTPUT_DATA_WIDTH)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr_s),
    .en      (rd_en_dly_q),
    .a       (feature_rdata),
    .b       (weight_rdata),
    .acc     (mac_acc_s),
    .acc_nxt (mac_acc_nxt_s)
  );

  assign fc_busy      = busy_q;
  assign rd_en        = rd_en_q;
  assign rd_addr      = index_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: a 50-entry 32-bit instance, a 16-bit wrap instance
// and a single-entry instance, each fed by a synchronous buffer model.
module tb_fc_layer_sequencer;
  import fc_pkg::*;

  localparam int N = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: default configuration
  logic        start_a, abort_a, busy_a, rd_en_a, valid_a, ready_a;
  logic [5:0]  addr_a;
  logic [7:0]  feat_a = 8'd0;
  logic [7:0]  wt_a   = 8'd0;
  logic [31:0] res_a;
  logic [7:0]  feat_mem [N];
  logic [7:0]  wt_mem   [N];
  logic [31:0] q_a [$];

  // Instance W: 16-bit accumulator, all operands 255
  logic        start_w, abort_w, busy_w, rd_en_w, valid_w, ready_w;
  logic [5:0]  addr_w;
  logic [7:0]  feat_w = 8'd0;
  logic [7:0]  wt_w   = 8'd0;
  logic [15:0] res_w;
  logic [31:0] q_w [$];

  // Instance 1: single-entry buffer
  logic        start_1, abort_1, busy_1, rd_en_1, valid_1, ready_1;
  logic [0:0]  addr_1;
  logic [7:0]  feat_1 = 8'd0;
  logic [7:0]  wt_1   = 8'd0;
  logic [31:0] res_1;
  logic [31:0] q_1 [$];

  fc_layer_sequencer #(
    .FLATTENED_LENGTH(N), .CONVOLUTION_DATA_WIDTH(8),
    .FULLYCONNECTED_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(32)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .fc_start(start_a), .fc_abort(abort_a), .fc_busy(busy_a),
    .rd_en(rd_en_a), .rd_addr(addr_a), .feature_rdata(feat_a), .weight_rdata(wt_a),
    .result(res_a), .result_valid(valid_a), .result_ready(ready_a)
  );

  fc_layer_sequencer #(
    .FLATTENED_LENGTH(N), .CONVOLUTION_DATA_WIDTH(8),
    .FULLYCONNECTED_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(16)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .fc_start(start_w), .fc_abort(abort_w), .fc_busy(busy_w),
    .rd_en(rd_en_w), .rd_addr(addr_w), .feature_rdata(feat_w), .weight_rdata(wt_w),
    .result(res_w), .result_valid(valid_w), .result_ready(ready_w)
  );

  fc_layer_sequencer #(
    .FLATTENED_LENGTH(1), .CONVOLUTION_DATA_WIDTH(8),
    .FULLYCONNECTED_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(32)
  ) dut_1 (
    .clk(clk), .rst_n(rst_n), .fc_start(start_1), .fc_abort(abort_1), .fc_busy(busy_1),
    .rd_en(rd_en_1), .rd_addr(addr_1), .feature_rdata(feat_1), .weight_rdata(wt_1),
    .result(res_1), .result_valid(valid_1), .result_ready(ready_1)
  );

  // Synchronous buffers: data appears exactly one cycle after rd_en
  always @(posedge clk) begin
    if (rd_en_a) begin
      feat_a <= feat_mem[addr_a];
      wt_a   <= wt_mem[addr_a];
    end
    if (rd_en_w) begin
      feat_w <= 8'd255;
      wt_w   <= 8'd255;
    end
    if (rd_en_1) begin
      feat_1 <= 8'd7;
      wt_1   <= 8'd9;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_a();
    logic [31:0] s = 32'd0;
    for (int i = 0; i < N; i++) s = s + 32'(feat_mem[i]) * 32'(wt_mem[i]);
    return s;
  endfunction

  // Scoreboard monitors: compare on every handshake
  always @(negedge clk) begin
    if (rst_n && valid_a && ready_a) begin
      if (q_a.size() == 0) check("a_spurious_valid", 32'(valid_a), 32'd0);
      else                 check("a_result", res_a, q_a.pop_front());
    end
    if (rst_n && valid_w && ready_w) begin
      if (q_w.size() == 0) check("w_spurious_valid", 32'(valid_w), 32'd0);
      else                 check("w_result_wrap", 32'(res_w), q_w.pop_front());
    end
    if (rst_n && valid_1 && ready_1) begin
      if (q_1.size() == 0) check("n1_spurious_valid", 32'(valid_1), 32'd0);
      else                 check("n1_result", res_1, q_1.pop_front());
    end
  end

  task automatic run_a(input bit chk);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (chk) begin
        check("run_rd_en", 32'(rd_en_a), 32'd1);
        check("run_rd_addr", 32'(addr_a), 32'(i));
        check("run_busy", 32'(busy_a), 32'd1);
      end
      step();
    end
    check("drain_rd_en", 32'(rd_en_a), 32'd0);
    check("drain_addr_hold", 32'(addr_a), 32'(N - 1));
    check("drain_no_valid", 32'(valid_a), 32'd0);
    step();
    check("valid_at_n_plus_2", 32'(valid_a), 32'd1);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < N; i++) begin
      feat_mem[i] = 8'($urandom_range(0, 255));
      wt_mem[i]   = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp;
    logic [15:0] sw;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
    start_w = 1'b0; abort_w = 1'b0; ready_w = 1'b1;
    start_1 = 1'b0; abort_1 = 1'b0; ready_1 = 1'b1;
    for (int i = 0; i < N; i++) begin
      feat_mem[i] = 8'(i + 1);
      wt_mem[i]   = 8'd1;
    end
    #12;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_rd_en", 32'(rd_en_a), 32'd0);
    check("rst_rd_addr", 32'(addr_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_result", res_a, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Ramp features, unit weights
    q_a.push_back(model_a());
    run_a(1'b1);
    step();
    check("t1_idle_valid", 32'(valid_a), 32'd0);
    check("t1_idle_busy", 32'(busy_a), 32'd0);
    check("t1_result_hold", res_a, 32'd1275);

    // Backpressure: result held, start ignored while busy and in the handshake cycle
    randomize_mem();
    exp = model_a();
    q_a.push_back(exp);
    ready_a = 1'b0;
    run_a(1'b0);
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", 32'(valid_a), 32'd1);
      check("hold_result", res_a, exp);
      check("hold_busy", 32'(busy_a), 32'd1);
      start_a = (k == 3);
      step();
    end
    start_a = 1'b1;
    ready_a = 1'b1;
    step();
    start_a = 1'b0;
    ready_a = 1'b0;
    check("hs_next_valid", 32'(valid_a), 32'd0);
    check("hs_next_busy", 32'(busy_a), 32'd0);
    step();
    step();
    check("start_not_queued_busy", 32'(busy_a), 32'd0);
    check("start_not_queued_rd_en", 32'(rd_en_a), 32'd0);
    ready_a = 1'b1;

    // Abort mid-run at T+20, then abort with start in IDLE, then a clean rerun
    for (int i = 0; i < N; i++) begin
      feat_mem[i] = 8'(i + 1);
      wt_mem[i]   = 8'd1;
    end
    q_a.push_back(model_a());
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (19) step();
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    void'(q_a.pop_back());
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_rd_en", 32'(rd_en_a), 32'd0);
    check("abort_valid", 32'(valid_a), 32'd0);
    repeat (60) step();
    check("abort_stays_idle", 32'(busy_a), 32'd0);
    abort_a = 1'b1;
    start_a = 1'b1;
    step();
    abort_a = 1'b0;
    start_a = 1'b0;
    check("abort_start_idle", 32'(busy_a), 32'd0);
    for (int i = 0; i < N; i++) wt_mem[i] = 8'd2;
    q_a.push_back(model_a());
    run_a(1'b0);
    step();

    // Asynchronous reset at T+30, then a fresh run
    randomize_mem();
    q_a.push_back(model_a());
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (29) step();
    rst_n = 1'b0;
    #1;
    void'(q_a.pop_back());
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_rd_en", 32'(rd_en_a), 32'd0);
    check("arst_rd_addr", 32'(addr_a), 32'd0);
    check("arst_valid", 32'(valid_a), 32'd0);
    check("arst_result", res_a, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    randomize_mem();
    q_a.push_back(model_a());
    run_a(1'b1);
    step();

    // 16-bit wrap
    sw = 16'd0;
    for (int i = 0; i < N; i++) sw = sw + 16'(32'd255 * 32'd255);
    q_w.push_back(32'(sw));
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    for (int k = 0; k < 100 && !valid_w; k++) step();
    check("w_valid_seen", 32'(valid_w), 32'd1);
    step();

    // Single-entry buffer
    q_1.push_back(32'd7 * 32'd9);
    start_1 = 1'b1;
    step();
    start_1 = 1'b0;
    check("n1_rd_en_t1", 32'(rd_en_1), 32'd1);
    check("n1_rd_addr_t1", 32'(addr_1), 32'd0);
    step();
    check("n1_rd_en_t2", 32'(rd_en_1), 32'd0);
    check("n1_valid_t2", 32'(valid_1), 32'd0);
    step();
    check("n1_valid_t3", 32'(valid_1), 32'd1);
    step();
    check("n1_valid_after_hs", 32'(valid_1), 32'd0);

    step();
    check("sb_a_empty", 32'(q_a.size()), 32'd0);
    check("sb_w_empty", 32'(q_w.size()), 32'd0);
    check("sb_1_empty", 32'(q_1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
